// File: rtl/demux4_fifo.sv
// Routes one valid/ready beat stream into four independent per-destination FIFOs,
// so a stalled consumer only back-pressures beats addressed to it.
module demux4_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [1:0]             in_sel,
   output logic [3:0]             out_valid,
   input  logic [3:0]             out_ready,
   output logic [WIDTH-1:0]       out_data0,
   output logic [WIDTH-1:0]       out_data1,
   output logic [WIDTH-1:0]       out_data2,
   output logic [WIDTH-1:0]       out_data3,
   output logic [4*(PTR_W+1)-1:0] occ
);

   // Handshake: a beat moves on a rising edge when valid && ready on that side;
   // valid never waits on ready, and in_ready depends only on registered counts.
   localparam logic [PTR_W:0]   cnt_full = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   cnt_one  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ptr_one  = PTR_W'(1);

   logic [3:0][PTR_W:0]   cnt_all;
   logic [3:0][WIDTH-1:0] head;

   assign in_ready  = (cnt_all[in_sel] != cnt_full);
   assign occ       = cnt_all;
   assign out_data0 = head[0];
   assign out_data1 = head[1];
   assign out_data2 = head[2];
   assign out_data3 = head[3];

   for (genvar i = 0; i < 4; i++) begin : g_fifo
      logic [WIDTH-1:0] mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [PTR_W:0]   cnt;
      logic             push;
      logic             pop;

      assign push = in_valid && in_ready && (in_sel == 2'(i));
      assign pop  = out_valid[i] && out_ready[i];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= in_data;
               wr_ptr      <= wr_ptr + ptr_one;
            end
            if (pop) rd_ptr <= rd_ptr + ptr_one;
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
               2'b10:   cnt <= cnt + cnt_one;
               2'b01:   cnt <= cnt - cnt_one;
               default: cnt <= cnt;
            endcase
         end
      end

      assign out_valid[i] = (cnt != '0);
      assign cnt_all[i]   = cnt;
      assign head[i]      = mem[rd_ptr];
   end

endmodule

// File: tb/tb_demux4_fifo.sv
// Directed bench for demux4_fifo: hand-computed expectations plus a small
// expected-queue model for the wrap-around stream through FIFO 0.
module tb_demux4_fifo;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [7:0]  occ;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  demux4_fifo #(.WIDTH(32), .DEPTH(2), .PTR_W(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .occ       (occ)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] sel, input logic [31:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    #1;
    check("async_reset_valid", 64'(out_valid), 64'h0);

    // reset state
    do_reset();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_occ", 64'(occ), 64'h0);
    check("rst_data", {out_data0 | out_data1, out_data2 | out_data3}, 64'h0);

    // 1: single push to sel 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hDEADBEEF;
    #1;
    check("t1_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_out_valid", 64'(out_valid), 64'h4);
    check("t1_out_data2", 64'(out_data2), 64'hDEADBEEF);
    check("t1_occ", 64'(occ), 64'h10);

    // 2: fill FIFO 1, bypass to FIFO 3, drain FIFO 1 in order
    do_reset();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    tick();
    #1;
    check("t2_full_ready", 64'(in_ready), 64'h0);
    check("t2_full_occ", 64'(occ), 64'h08);
    in_sel = 2'd3; in_data = 32'h33333333;
    #1;
    check("t2_sel3_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    in_sel   = 2'd1;
    out_ready = 4'b0010;
    #1;
    check("t2_out_valid", 64'(out_valid), 64'hA);
    check("t2_out_data3", 64'(out_data3), 64'h33333333);
    check("t2_ready_while_pop", 64'(in_ready), 64'h0);
    check("t2_head_first", 64'(out_data1), 64'h11111111);
    tick();
    check("t2_ready_after_pop", 64'(in_ready), 64'h1);
    check("t2_head_second", 64'(out_data1), 64'h22222222);
    tick();
    out_ready = '0;
    #1;
    check("t2_drained", 64'(out_valid), 64'h8);

    // 3: simultaneous push and pop on FIFO 0
    do_reset();
    push(2'd0, 32'hAAAA0000);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hBBBB0000; out_ready = 4'b0001;
    #1;
    check("t3_head_a", 64'(out_data0), 64'hAAAA0000);
    tick();
    in_valid = 1'b0; out_ready = '0;
    #1;
    check("t3_occ", 64'(occ), 64'h01);
    check("t3_head_b", 64'(out_data0), 64'hBBBB0000);

    // 4: stream 0..4 through FIFO 0 across pointer wrap (scoreboard)
    do_reset();
    out_ready = 4'b0001;
    in_sel    = 2'd0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 5);
      in_data  = 32'(k);
      #1;
      check($sformatf("t4_valid_%0d", k), 64'(out_valid[0]), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check($sformatf("t4_data_%0d", k), 64'(out_data0), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (k < 5) exp_q.push_back(32'(k));
      tick();
    end
    in_valid = 1'b0; out_ready = '0;
    #1;
    check("t4_occ_end", 64'(occ), 64'h0);
    check("t4_q_empty", 64'(exp_q.size()), 64'h0);

    // 5: parallel drain
    do_reset();
    for (int i = 0; i < 4; i++) push(2'(i), 32'h10 + 32'(i));
    check("t5_all_valid", 64'(out_valid), 64'hF);
    check("t5_occ", 64'(occ), 64'h55);
    check("t5_data", {out_data0[15:0], out_data1[15:0], out_data2[15:0], out_data3[15:0]},
          64'h0010_0011_0012_0013);
    out_ready = 4'b1111;
    tick();
    out_ready = '0;
    #1;
    check("t5_drained_valid", 64'(out_valid), 64'h0);
    check("t5_drained_occ", 64'(occ), 64'h0);

    // 6: asynchronous reset mid-cycle with FIFOs 0 and 2 full
    do_reset();
    push(2'd0, 32'hA0);
    push(2'd0, 32'hA1);
    push(2'd2, 32'hC0);
    push(2'd2, 32'hC1);
    check("t6_full_occ", 64'(occ), 64'h22);
    check("t6_full_valid", 64'(out_valid), 64'h5);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'h0);
    check("t6_async_occ", 64'(occ), 64'h0);
    check("t6_async_data", {out_data0, out_data2}, 64'h0);
    reset = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h77;
    #1;
    check("t6_ready_after", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("t6_first_push", 64'(out_data0), 64'h77);
    check("t6_first_occ", 64'(occ), 64'h01);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux4_fifo.md
Name: demux4_fifo

Overview:
- Routes one 32-bit result stream to one of four consumers, selected per beat by a 2-bit select.
- Each destination has its own small FIFO, so a stalled consumer does not block beats bound for the other three.
- Sits between a shared execute/result source and four independent sinks in the pipeline, for example writeback, CSR/system, load-store and debug.
- Valid/ready handshake on the input side and on every output side.

Parameters:
- WIDTH, 32, data width of every lane.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and at least 2.
- PTR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  source presents a beat
- in_ready  output  1  selected destination FIFO can accept the beat
- in_data  input  WIDTH  beat payload
- in_sel  input  2  destination index: 00→0, 01→1, 10→2, 11→3
- out_valid  output  4  bit i high = FIFO i non-empty
- out_ready  input  4  bit i high = consumer i takes the head of FIFO i
- out_data0  output  WIDTH  head entry of FIFO 0
- out_data1  output  WIDTH  head entry of FIFO 1
- out_data2  output  WIDTH  head entry of FIFO 2
- out_data3  output  WIDTH  head entry of FIFO 3
- occ  output  4*(PTR_W+1)  packed occupancy counts; count i occupies bits [i*(PTR_W+1) +: PTR_W+1]

Behaviour:
- State per FIFO i:
  - storage mem_i[DEPTH]
  - wr_ptr_i and rd_ptr_i, PTR_W bits each, wrapping modulo DEPTH
  - cnt_i, PTR_W+1 bits, range 0..DEPTH
- Reset (asynchronous, takes effect immediately):
  - all cnt, wr_ptr, rd_ptr and every storage entry are cleared to 0
  - out_valid = 4'b0000, all out_dataN = 0, occ = 0
- in_ready:
  - in_ready = (cnt[in_sel] != DEPTH), decoded only from registered state
  - No combinational path from out_ready to in_ready: a full FIFO refuses a push even in a cycle where it pops.
- Push:
  - fires when in_valid && in_ready
  - on the clock edge, mem_sel[wr_ptr_sel] <= in_data and wr_ptr_sel increments with wrap
  - only FIFO in_sel is written; the other three are untouched
- Pop on FIFO i:
  - fires when out_valid[i] && out_ready[i]
  - rd_ptr_i increments with wrap
  - out_ready[i] while FIFO i is empty has no effect
- Outputs:
  - out_valid[i] = (cnt_i != 0)
  - out_dataN = mem_N[rd_ptr_N], combinational from registers
  - Latency: a beat pushed at edge k is visible on out_valid/out_dataN from edge k onward, i.e. consumable in the following cycle. There is no bypass from input to output in the same cycle.
- Count update per FIFO:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle (possible only when 0 < cnt < DEPTH): unchanged
  - Pointers each advance independently.
- Pops on several FIFOs in the same cycle are all independent and all legal.
- Ordering:
  - strict FIFO order within each destination
  - no ordering guarantee between destinations
- When in_valid is low, in_sel and in_data are ignored for state; in_ready still reflects cnt[in_sel].
- Source obligation: once in_valid is high it must be held with stable in_data and in_sel until accepted. The block does not check this.
- Reset mid-operation: all buffered beats are discarded, with no partial pop or push. The first edge after reset deasserts starts from the empty state.

Test Plan:
1. Reset, then in_valid=1, in_sel=2, in_data=32'hDEADBEEF for one cycle with out_ready=0 → next cycle out_valid=4'b0100, out_data2=DEADBEEF, count 2 = 1, other counts 0.
2. Fill FIFO 1 by pushing 11111111 then 22222222 with out_ready=0 → in_ready=0 while in_sel=1. Switch in_sel=3 → in_ready=1 and 33333333 lands in FIFO 3. Set out_ready[1]=1 → 11111111 then 22222222 drain in order, and in_ready for sel 1 returns to 1 only after the first pop edge.
3. FIFO 0 holds one entry A; in the same cycle push B to sel 0 and out_ready[0]=1 → count 0 stays 1 and out_data0 becomes B next cycle.
4. Wrap: push and pop 5 sequential values 0..4 through FIFO 0 with out_ready[0]=1 → outputs appear in order 0,1,2,3,4 across pointer wrap, and count ends at 0.
5. Parallel drain: FIFOs 0–3 each hold one entry; assert out_ready=4'b1111 for one cycle → out_valid=4'b0000 next cycle, all counts 0.
6. FIFOs 0 and 2 full; assert reset asynchronously mid-cycle → out_valid=0 and occ=0 immediately, without waiting for a clock edge. After release, the first push to sel 0 is accepted.
